// File: rtl/hs_pkg.sv
// Shared types and width helpers for the round-robin handshake collector.
// Used by hs_fifo and hs_rr_collector.
package hs_pkg;

   typedef enum logic [0:0] {
      HS_IDLE = 1'b0,
      HS_ACK  = 1'b1
   } hs_state_e;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Occupancy counters must be able to hold the value n itself.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hs_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; push and pop may
// coincide at any occupancy, including full.
module hs_fifo
   import hs_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      pop,
   output logic [WIDTH-1:0]          rdata,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int AW = idx_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage is cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (!do_push && do_pop) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/hs_rr_collector.sv
// Collects words from NCH four-phase req/ack producers, round-robin, into a FIFO
// feeding one valid/ready stream. Define HS_TIMEOUT_EN to enable the ACK-hold timeout.
module hs_rr_collector
   import hs_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int SYNC    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic                     clkA,
   input  logic                     reset,
   input  logic [NCH-1:0]           req,
   input  logic [NCH*DW-1:0]        data,
   output logic [NCH-1:0]           ack,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_data,
   output logic [idx_w(NCH)-1:0]    out_ch,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     err,
   output logic [idx_w(NCH)-1:0]    err_ch
);

   localparam int CW = idx_w(NCH);
   localparam int EW = DW + CW;

   logic [NCH-1:0] sync_q [SYNC];
   logic [NCH-1:0] sreq;
   logic [NCH-1:0] eligible;
   hs_state_e      state;
   logic [CW-1:0]  ptr;
   logic [CW-1:0]  gch;
   logic [CW-1:0]  gsel;
   logic [CW-1:0]  ptr_next;
   logic           found;
   logic           grant;
   logic           tmo_hit;
   logic           fifo_full;
   logic           fifo_empty;
   logic [EW-1:0]  fifo_wdata;
   logic [EW-1:0]  fifo_rdata;

   // req may be asynchronous, so nothing downstream looks at it unsynchronised.
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= req;
         for (int i = 1; i < SYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sreq = sync_q[SYNC-1];

   always_comb begin
      found = 1'b0;
      gsel  = '0;
      for (int k = 0; k < NCH; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NCH) begin
            j = j - NCH;
         end
         if (!found && eligible[j]) begin
            found = 1'b1;
            gsel  = CW'(j);
         end
      end
   end

   assign ptr_next   = (gsel == CW'(NCH - 1)) ? '0 : gsel + CW'(1);
   assign grant      = (state == HS_IDLE) && found && !fifo_full;
   assign fifo_wdata = {gsel, data[int'(gsel)*DW +: DW]};

   // A granted channel keeps ack until its synchronised req drops (or times out).
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         state <= HS_IDLE;
         ack   <= '0;
         ptr   <= '0;
         gch   <= '0;
      end else begin
         case (state)
            HS_IDLE: begin
               if (grant) begin
                  ack       <= '0;
                  ack[gsel] <= 1'b1;
                  gch       <= gsel;
                  ptr       <= ptr_next;
                  state     <= HS_ACK;
               end
            end
            HS_ACK: begin
               if (!sreq[gch] || tmo_hit) begin
                  ack   <= '0;
                  state <= HS_IDLE;
               end
            end
            default: begin
               ack   <= '0;
               state <= HS_IDLE;
            end
         endcase
      end
   end

`ifdef HS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0]  tmo_cnt;
   logic [NCH-1:0] mask;

   assign tmo_hit  = (state == HS_ACK) && sreq[gch] && (tmo_cnt == TW'(TIMEOUT - 1));
   assign eligible = sreq & ~mask;

   // A timed-out channel stays masked until its req is seen low.
   always_ff @(posedge clkA or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
         mask    <= '0;
         err     <= 1'b0;
         err_ch  <= '0;
      end else begin
         err  <= 1'b0;
         mask <= mask & sreq;
         if (state != HS_ACK) begin
            tmo_cnt <= '0;
         end else if (tmo_hit) begin
            tmo_cnt   <= '0;
            err       <= 1'b1;
            err_ch    <= gch;
            mask[gch] <= 1'b1;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit        = 1'b0;
   assign eligible       = sreq;
   assign err            = 1'b0;
   assign err_ch         = '0;
`endif

   hs_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clkA),
      .reset (reset),
      .push  (grant),
      .wdata (fifo_wdata),
      .pop   (out_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign out_valid = !fifo_empty;
   assign out_ch    = fifo_rdata[EW-1 -: CW];
   assign out_data  = fifo_rdata[DW-1:0];

endmodule

// File: tb/tb_hs_rr_collector.sv
// Directed self-checking bench for hs_rr_collector (NCH=4, DW=8, DEPTH=4, SYNC=2).
// The timeout scenario is compiled only when HS_TIMEOUT_EN is defined.
module tb_hs_rr_collector;

   localparam int NCH   = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic              clkA = 1'b0;
   logic              reset;
   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] data;
   logic [NCH-1:0]    ack;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_ch;
   logic [2:0]        count;
   logic              err;
   logic [1:0]        err_ch;

   int             n_checks = 0;
   int             n_fail   = 0;
   int             pend [NCH];
   logic [NCH-1:0] hold;
   logic [7:0]     next_word [NCH];
   int             ack_rises [NCH];
   int             err_pulses;
   int             ack1_steps;
   int             max_ones;
   logic [NCH-1:0] prev_ack;
   logic [1:0]     got_ch [$];
   logic [7:0]     got_data [$];
   logic [7:0]     exp3 [4];

   always #5 clkA = ~clkA;

   hs_rr_collector #(
      .NCH     (NCH),
      .DW      (DW),
      .DEPTH   (DEPTH),
      .SYNC    (SYNC),
      .TIMEOUT (16)
   ) dut (
      .clkA      (clkA),
      .reset     (reset),
      .req       (req),
      .data      (data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .count     (count),
      .err       (err),
      .err_ch    (err_ch)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Four-phase producer model: raise req when idle with work, drop it once acked.
   task automatic applyStimulus();
      for (int c = 0; c < NCH; c++) begin
         if (req[c] && ack[c] && !hold[c]) begin
            req[c] = 1'b0;
         end else if (!req[c] && !ack[c] && pend[c] > 0) begin
            data[c*DW +: DW] = next_word[c];
            next_word[c]     = next_word[c] + 8'd1;
            pend[c]          = pend[c] - 1;
            req[c]           = 1'b1;
         end
      end
   endtask

   task automatic clearStats();
      for (int c = 0; c < NCH; c++) begin
         ack_rises[c] = 0;
      end
      err_pulses = 0;
      ack1_steps = 0;
      got_ch.delete();
      got_data.delete();
   endtask

   task automatic runCycles(input int n);
      repeat (n) begin
         if (out_valid && out_ready) begin
            got_ch.push_back(out_ch);
            got_data.push_back(out_data);
         end
         @(posedge clkA);
         #1;
         for (int c = 0; c < NCH; c++) begin
            if (ack[c] && !prev_ack[c]) ack_rises[c]++;
         end
         prev_ack = ack;
         if ($countones(ack) > max_ones) max_ones = $countones(ack);
         if (err) err_pulses++;
         if (ack[1]) ack1_steps++;
         applyStimulus();
      end
   endtask

   task automatic applyReset();
      reset     = 1'b0;
      req       = '0;
      data      = '0;
      out_ready = 1'b0;
      hold      = '0;
      prev_ack  = '0;
      for (int c = 0; c < NCH; c++) begin
         pend[c] = 0;
      end
      repeat (2) @(posedge clkA);
      #1;
      reset = 1'b1;
      clearStats();
   endtask

   task automatic checkOrder(input string tag);
      checkOutput({tag, "_n"}, got_ch.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_ch.size()) begin
            checkOutput($sformatf("%s_ch%0d", tag, i), got_ch[i], i);
            checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp3[i]);
         end
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      exp3     = '{8'h10, 8'h21, 8'h32, 8'h43};
      max_ones = 0;
      reset    = 1'b1;
      req      = '0;
      data     = '0;
      out_ready = 1'b0;
      hold     = '0;
      prev_ack = '0;
      for (int c = 0; c < NCH; c++) begin
         pend[c]      = 0;
         next_word[c] = 8'h00;
      end
      clearStats();

      // Reset state, during and after reset with no requests
      #2;
      reset = 1'b0;
      #10;
      checkOutput("rst_ack_during", ack, 0);
      checkOutput("rst_count_during", count, 0);
      @(posedge clkA);
      #1;
      reset = 1'b1;
      runCycles(5);
      checkOutput("rst_ack", ack, 0);
      checkOutput("rst_ack_rises", ack_rises[0] + ack_rises[1] + ack_rises[2] + ack_rises[3], 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_ch", out_ch, 0);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_err_ch", err_ch, 0);

      // Single handshake on ch2 with exact latencies
      hold[2]        = 1'b1;
      data[2*DW +: DW] = 8'hA5;
      req[2]         = 1'b1;
      runCycles(2);
      checkOutput("s2_ack_early", ack, 4'b0000);
      runCycles(1);
      checkOutput("s2_ack_rise", ack, 4'b0100);
      runCycles(1);
      checkOutput("s2_out_valid", out_valid, 1);
      checkOutput("s2_out_data", out_data, 8'hA5);
      checkOutput("s2_out_ch", out_ch, 2);
      checkOutput("s2_count", count, 1);
      req[2] = 1'b0;
      runCycles(2);
      checkOutput("s2_ack_hold", ack, 4'b0100);
      runCycles(1);
      checkOutput("s2_ack_fall", ack, 4'b0000);
      checkOutput("s2_stable_data", out_data, 8'hA5);
      out_ready = 1'b1;
      runCycles(1);
      out_ready = 1'b0;
      checkOutput("s2_pop_count", count, 0);
      checkOutput("s2_pop_valid", out_valid, 0);

      // All four channels at once: round-robin order, twice
      applyReset();
      out_ready = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         next_word[c] = exp3[c];
         pend[c]      = 1;
      end
      runCycles(40);
      checkOrder("rr1");
      clearStats();
      for (int c = 0; c < NCH; c++) begin
         next_word[c] = exp3[c];
         pend[c]      = 1;
      end
      runCycles(40);
      checkOrder("rr2");
      checkOutput("rr_ack_onehot", (max_ones <= 1), 1);

      // Back-pressure: fifth word on ch1 waits for a pop
      clearStats();
      out_ready    = 1'b0;
      next_word[1] = 8'h60;
      pend[1]      = 5;
      runCycles(45);
      checkOutput("bp_acks_full", ack_rises[1], 4);
      checkOutput("bp_count_full", count, 4);
      checkOutput("bp_no_ack", ack, 0);
      out_ready = 1'b1;
      runCycles(1);
      out_ready = 1'b0;
      checkOutput("bp_pop_n", got_data.size(), 1);
      if (got_data.size() > 0) begin
         checkOutput("bp_pop_data", got_data[0], 8'h60);
         checkOutput("bp_pop_ch", got_ch[0], 1);
      end
      runCycles(12);
      checkOutput("bp_acks_after", ack_rises[1], 5);
      checkOutput("bp_count_after", count, 4);
      checkOutput("bp_head_data", out_data, 8'h61);
`ifndef HS_TIMEOUT_EN
      checkOutput("bp_err_quiet", err_pulses, 0);
`endif

`ifdef HS_TIMEOUT_EN
      // ch1 holds req: timeout, error pulse, masking while ch0 is served
      applyReset();
      out_ready    = 1'b1;
      hold[1]      = 1'b1;
      next_word[1] = 8'h77;
      pend[1]      = 1;
      runCycles(5);
      next_word[0] = 8'h05;
      pend[0]      = 2;
      runCycles(50);
      checkOutput("to_ack1_cycles", ack1_steps, 16);
      checkOutput("to_err_pulses", err_pulses, 1);
      checkOutput("to_err_ch", err_ch, 1);
      checkOutput("to_ch0_served", ack_rises[0], 2);
      checkOutput("to_ch1_masked", ack_rises[1], 1);
      if (got_data.size() > 0) begin
         checkOutput("to_word_kept", got_data[0], 8'h77);
      end
      req[1]  = 1'b0;
      hold[1] = 1'b0;
      runCycles(6);
      next_word[1] = 8'h78;
      pend[1]      = 1;
      runCycles(20);
      checkOutput("to_ch1_regrant", ack_rises[1], 2);
      checkOutput("to_err_once", err_pulses, 1);
`endif

      // Reset mid-handshake with ack[3] high and two words buffered
      applyReset();
      out_ready    = 1'b0;
      next_word[0] = 8'h01;
      pend[0]      = 1;
      next_word[3] = 8'h03;
      pend[3]      = 1;
      hold[3]      = 1'b1;
      guard        = 0;
      while (!ack[3] && guard < 40) begin
         runCycles(1);
         guard++;
      end
      checkOutput("mr_ack3_seen", ack[3], 1);
      checkOutput("mr_count_before", count, 2);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mr_ack", ack, 0);
      checkOutput("mr_count", count, 0);
      checkOutput("mr_out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
